fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Fetch controller: buffers fetched {pc, instr} pairs in a 4-entry FIFO, issues them to decode,
// and steers the PC for branch redirects and for replay after a FIFO-overflow drop.
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc_addr,
    input  logic [15:0] imem_rdata,
    output logic [1:0]  pc_sel,
    output logic [15:0] pc_tgt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    input  logic        br_resolve,
    input  logic        br_taken,
    input  logic [15:0] br_tgt
);
    localparam int unsigned XW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 2;
    localparam int unsigned CW    = 3;
    localparam int unsigned IMMW  = 7;

    localparam logic [1:0] SEL_INC  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b10;

    typedef struct packed {
        logic [XW-1:0] pc;
        logic [XW-1:0] instr;
    } fentry_t;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_BR_WAIT = 2'd1,
        S_SQUASH  = 2'd2,
        S_REPLAY  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   fpc_q;
    logic            fvld_q;
    fentry_t         fifo_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            drop_pend_q, drop_pend_d;
    logic [XW-1:0]   replay_pc_q, replay_pc_d;
    logic [XW-1:0]   br_pc_q, br_pc_d;
    logic [IMMW-1:0] br_imm_q, br_imm_d;
    logic            br_jalr_q, br_jalr_d;

    fentry_t head;
    logic    issue_st;
    logic    pop;
    logic    head_br;
    logic    squash;
    logic    flush;
    logic    drop_clr;
    logic    push_att;
    logic    full;
    logic    push;
    logic    drop;

    // Issue side is a direct view of the FIFO head, gated so idle outputs read as zero
    assign head      = fifo_q[rd_ptr_q];
    assign issue_st  = (state_q == S_RUN) || (state_q == S_REPLAY);
    assign out_valid = issue_st && (cnt_q != '0);
    assign out_pc    = out_valid ? head.pc : '0;
    assign out_instr = out_valid ? head.instr : '0;
    assign pop       = out_valid && out_ready;
    assign head_br   = (head.instr[XW-1 -: 2] == 2'b11);

    // Control FSM; redirects are combinational so the PC loads the target on the next edge
    always_comb begin
        state_d   = state_q;
        pc_sel    = SEL_INC;
        pc_tgt    = '0;
        flush     = 1'b0;
        drop_clr  = 1'b0;
        squash    = (state_q == S_SQUASH);
        br_pc_d   = br_pc_q;
        br_imm_d  = br_imm_q;
        br_jalr_d = br_jalr_q;

        unique case (state_q)
            S_RUN, S_REPLAY: begin
                if (drop_pend_q && (cnt_q == '0)) begin
                    pc_sel   = SEL_LOAD;
                    pc_tgt   = replay_pc_q;
                    drop_clr = 1'b1;
                    squash   = 1'b1;
                    state_d  = S_SQUASH;
                end else if (pop && head_br) begin
                    br_pc_d   = head.pc;
                    br_imm_d  = head.instr[IMMW-1:0];
                    br_jalr_d = head.instr[XW-3];
                    state_d   = S_BR_WAIT;
                end
            end
            S_BR_WAIT: begin
                if (br_resolve) begin
                    if (br_jalr_q || br_taken) begin
                        pc_sel   = SEL_LOAD;
                        pc_tgt   = br_jalr_q ? br_tgt
                                 : br_pc_q + XW'(1) + {{(XW-IMMW){br_imm_q[IMMW-1]}}, br_imm_q};
                        flush    = 1'b1;
                        drop_clr = 1'b1;
                        squash   = 1'b1;
                        state_d  = S_SQUASH;
                    end else begin
                        state_d = drop_pend_q ? S_REPLAY : S_RUN;
                    end
                end
            end
            S_SQUASH: state_d = S_RUN;
            default:  state_d = S_RUN;
        endcase
    end

    // Once an entry is dropped everything younger is discarded until the replay redirect
    always_comb begin
        push_att    = fvld_q && !squash;
        full        = (cnt_q == CW'(DEPTH));
        push        = push_att && !drop_pend_q && (!full || pop);
        drop        = push_att && !drop_pend_q && full && !pop;
        drop_pend_d = drop_clr ? 1'b0 : (drop ? 1'b1 : drop_pend_q);
        replay_pc_d = drop ? fpc_q : replay_pc_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            cnt_d    = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            fpc_q       <= '0;
            fvld_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            drop_pend_q <= 1'b0;
            replay_pc_q <= '0;
            br_pc_q     <= '0;
            br_imm_q    <= '0;
            br_jalr_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fpc_q       <= pc_addr;
            fvld_q      <= 1'b1;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            drop_pend_q <= drop_pend_d;
            replay_pc_q <= replay_pc_d;
            br_pc_q     <= br_pc_d;
            br_imm_q    <= br_imm_d;
            br_jalr_q   <= br_jalr_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= '{pc: fpc_q, instr: imem_rdata};
            end
        end
    end

endmodule
